rr_arbiter: RTL and testbench



---
 rtl/rr_arbiter.sv | 116 +++++++++++
 tb/tb_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant held under a valid/ack handshake, with a
// one-hot priority pointer that moves one past each acknowledged winner.
module rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req,
   input  logic             grant_ack,
   output logic             grant_valid,
   output logic [WIDTH-1:0] grant,
   output logic [IDW-1:0]   grant_id,
   output logic [WIDTH-1:0] prio
);

   localparam logic [WIDTH-1:0] PRIO_RST = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [WIDTH-1:0] next_prio;
   logic [IDW-1:0]   prio_idx;
   logic [WIDTH-1:0] winner;
   logic             any_req;
   logic             xfer;

   function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   function automatic logic [WIDTH-1:0] rotr_by(input logic [WIDTH-1:0] v,
                                                input logic [IDW-1:0]   k);
      logic [2*WIDTH-1:0] d;
      d = {v, v} >> k;
      return d[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] rotl_by(input logic [WIDTH-1:0] v,
                                                input logic [IDW-1:0]   k);
      logic [2*WIDTH-1:0] d;
      d = {v, v} << k;
      return d[2*WIDTH-1:WIDTH];
   endfunction

   function automatic logic [WIDTH-1:0] lowest_one(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      logic             found;
      r     = '0;
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i] && !found) begin
            r[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [IDW-1:0] enc(input logic [WIDTH-1:0] v);
      logic [IDW-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) r = IDW'(i);
      end
      return r;
   endfunction

   // Arbitration looks at the pointer as it will be after this edge, so an
   // ack and the following grant happen on the same edge.
   always_comb begin
      xfer      = (state == BUSY) && grant_ack;
      next_prio = xfer ? rotl1(grant) : prio;
      prio_idx  = enc(next_prio);
      any_req   = |req;
      winner    = '0;
      if (any_req) winner = rotl_by(lowest_one(rotr_by(req, prio_idx)), prio_idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         prio        <= PRIO_RST;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant       <= winner;
                  grant_id    <= enc(winner);
                  grant_valid <= 1'b1;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (grant_ack) begin
                  prio <= next_prio;
                  if (any_req) begin
                     grant    <= winner;
                     grant_id <= enc(winner);
                  end else begin
                     grant       <= '0;
                     grant_id    <= '0;
                     grant_valid <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed and randomized checks for rr_arbiter (WIDTH=8), including a
// reference pick model and a per-requester wait scoreboard.
module tb_rr_arbiter;

   localparam int WIDTH = 8;
   localparam int IDW   = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] req;
   logic             grant_ack;
   logic             grant_valid;
   logic [WIDTH-1:0] grant;
   logic [IDW-1:0]   grant_id;
   logic [WIDTH-1:0] prio;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rr_arbiter #(.WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant_ack   (grant_ack),
      .grant_valid (grant_valid),
      .grant       (grant),
      .grant_id    (grant_id),
      .prio        (prio)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [7:0] g,
                             input logic [2:0] id, input logic [7:0] p);
      check({tag, ".valid"}, 32'(grant_valid), 32'(v));
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".id"}, 32'(grant_id), 32'(id));
      check({tag, ".prio"}, 32'(prio), 32'(p));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   // Reference: scan upward from the pointer position for the first requester.
   function automatic logic [7:0] pick(input logic [7:0] r, input logic [7:0] p);
      int k;
      int idx;
      logic [7:0] w;
      k = 0;
      w = 8'h00;
      for (int j = 0; j < WIDTH; j++) if (p[j]) k = j;
      for (int j = 0; j < WIDTH; j++) begin
         idx = (k + j) % WIDTH;
         if (r[idx] && w == 8'h00) w = 8'(1 << idx);
      end
      return w;
   endfunction

   function automatic logic [2:0] idx_of(input logic [7:0] g);
      logic [2:0] r;
      r = 3'd0;
      for (int j = 0; j < WIDTH; j++) if (g[j]) r = 3'(j);
      return r;
   endfunction

   logic [7:0] m_prio, m_grant;
   logic       m_gv;
   int         wait_cnt [WIDTH];
   logic       over;

   initial begin
      rst_n = 1'b0;
      req = 8'h00;
      grant_ack = 1'b0;
      repeat (2) step();
      expect_out("rst", 1'b0, 8'h00, 3'd0, 8'h01);
      rst_n = 1'b1;
      step();

      // reset in the middle of a grant
      req = 8'h04;
      step();
      expect_out("pre_rst", 1'b1, 8'h04, 3'd2, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      expect_out("async_rst", 1'b0, 8'h00, 3'd0, 8'h01);
      req = 8'h00;
      step();
      rst_n = 1'b1;
      repeat (5) begin
         step();
         expect_out("idle", 1'b0, 8'h00, 3'd0, 8'h01);
      end

      // single requester
      req = 8'h10;
      step();
      expect_out("single", 1'b1, 8'h10, 3'd4, 8'h01);
      grant_ack = 1'b1;
      step();
      expect_out("single_again", 1'b1, 8'h10, 3'd4, 8'h20);
      req = 8'h00;
      step();
      expect_out("single_done", 1'b0, 8'h00, 3'd0, 8'h20);
      grant_ack = 1'b0;

      // full rotation with ack held high
      pulse_reset();
      req = 8'hFF;
      step();
      expect_out("rot0", 1'b1, 8'h01, 3'd0, 8'h01);
      grant_ack = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         expect_out("rot", 1'b1, 8'(1 << (i % 8)), 3'(i % 8), 8'(1 << (i % 8)));
      end
      req = 8'h00;
      step();
      expect_out("rot_end", 1'b0, 8'h00, 3'd0, 8'h02);
      grant_ack = 1'b0;

      // grant held without ack while req changes
      req = 8'h06;
      step();
      expect_out("hold0", 1'b1, 8'h02, 3'd1, 8'h02);
      req = 8'h04;
      step();
      expect_out("hold1", 1'b1, 8'h02, 3'd1, 8'h02);
      step();
      expect_out("hold2", 1'b1, 8'h02, 3'd1, 8'h02);
      req = 8'h00;
      step();
      expect_out("hold3", 1'b1, 8'h02, 3'd1, 8'h02);
      step();
      expect_out("hold4", 1'b1, 8'h02, 3'd1, 8'h02);
      grant_ack = 1'b1;
      step();
      expect_out("hold_rel", 1'b0, 8'h00, 3'd0, 8'h04);
      grant_ack = 1'b0;

      // pointer skip and wrap
      req = 8'h40;
      step();
      expect_out("skip0", 1'b1, 8'h40, 3'd6, 8'h04);
      req = 8'h41;
      grant_ack = 1'b1;
      step();
      expect_out("skip1", 1'b1, 8'h01, 3'd0, 8'h80);
      step();
      expect_out("skip2", 1'b1, 8'h40, 3'd6, 8'h02);
      req = 8'h00;
      step();
      expect_out("skip_end", 1'b0, 8'h00, 3'd0, 8'h80);

      // spurious ack while idle, then sole requester and simultaneous events
      repeat (3) begin
         step();
         expect_out("spur", 1'b0, 8'h00, 3'd0, 8'h80);
      end
      req = 8'h01;
      step();
      expect_out("idle_ack", 1'b1, 8'h01, 3'd0, 8'h80);
      step();
      expect_out("sole", 1'b1, 8'h01, 3'd0, 8'h02);
      req = 8'h03;
      step();
      expect_out("fair_sim", 1'b1, 8'h02, 3'd1, 8'h02);
      req = 8'h00;
      step();
      expect_out("sim_end", 1'b0, 8'h00, 3'd0, 8'h04);
      grant_ack = 1'b0;

      // random traffic against the reference model and wait scoreboard
      pulse_reset();
      m_prio = 8'h01;
      m_grant = 8'h00;
      m_gv = 1'b0;
      for (int i = 0; i < WIDTH; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         req = req ^ 8'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 63) == 0) req = 8'h00;
         grant_ack = 1'($urandom_range(0, 1));

         over = 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            if (grant_valid && grant_ack && grant[i]) wait_cnt[i] = 0;
            else if (!req[i]) wait_cnt[i] = 0;
            else if (grant_valid && grant_ack) wait_cnt[i]++;
            if (wait_cnt[i] > WIDTH) over = 1'b1;
         end
         if (grant_valid && grant_ack) check("fair_bound", 32'(over), 32'd0);

         if (m_gv && grant_ack) begin
            m_prio = {m_grant[6:0], m_grant[7]};
            if (|req) m_grant = pick(req, m_prio);
            else begin
               m_grant = 8'h00;
               m_gv = 1'b0;
            end
         end else if (!m_gv && |req) begin
            m_grant = pick(req, m_prio);
            m_gv = 1'b1;
         end

         step();
         expect_out("rand", m_gv, m_grant, idx_of(m_grant), m_prio);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
